// File: rtl/synth_voice_scheduler.sv
// synth_voice_scheduler
// Shares one waveform generator among NUM_VOICES phase-accumulator voices.
// Each sample tick makes one pass: every voice gets one issue slot in order,
// returned samples are summed and averaged, and the result goes out on a
// valid/ready port.
//
// Handshake: mix_valid rises with mix_data and both stay stable until a cycle
// where mix_valid && mix_ready, which is the single transfer; mix_valid drops
// on the following cycle.
module synth_voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int ACC_W      = 24,
  parameter int GEN_LAT    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic [ACC_W-1:0]              cfg_fcw,
  input  logic                          cfg_en,
  output logic [14:0]                   gen_phase,
  input  logic [11:0]                   gen_wave,
  output logic [11:0]                   mix_data,
  output logic                          mix_valid,
  input  logic                          mix_ready,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int SUM_W  = 12 + IDX_W;
  localparam int DCNT_W = $clog2(GEN_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        idx;
  logic [DCNT_W-1:0]       dcnt;
  logic [ACC_W-1:0]        phase [NUM_VOICES];
  logic [ACC_W-1:0]        fcw   [NUM_VOICES];
  logic [NUM_VOICES-1:0]   en;
  // tag[0] is registered alongside gen_phase; tag[GEN_LAT] lines up with gen_wave.
  logic [GEN_LAT:0]        tag;
  logic [SUM_W-1:0]        sum;
  logic [SUM_W-1:0]        sum_nxt;
  logic [ACC_W-1:0]        adv_phase;
  logic                    issue_last;
  logic                    drain_done;

  // Advanced phase of the slot voice, running sum including this cycle's sample.
  always_comb begin
    adv_phase  = phase[idx] + fcw[idx];
    sum_nxt    = sum + (tag[GEN_LAT] ? SUM_W'(gen_wave) : '0);
    issue_last = (idx == IDX_W'(NUM_VOICES - 1));
    drain_done = (dcnt == DCNT_W'(GEN_LAT));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_tick) state_nxt = ISSUE;
      ISSUE:   if (issue_last)  state_nxt = DRAIN;
      DRAIN:   if (drain_done)  state_nxt = OUTPUT;
      OUTPUT:  if (mix_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Pass datapath: slot counter, generator issue, tag pipe, sum, mix output.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      dcnt      <= '0;
      tag       <= '0;
      sum       <= '0;
      gen_phase <= '0;
      mix_data  <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      tag <= {tag[GEN_LAT-1:0], (state == ISSUE) && en[idx]};
      case (state)
        IDLE: begin
          if (sample_tick) begin
            sum <= '0;
            idx <= '0;
          end
        end
        ISSUE: begin
          idx       <= idx + IDX_W'(1);
          dcnt      <= '0;
          sum       <= sum_nxt;
          gen_phase <= en[idx] ? adv_phase[ACC_W-1 -: 15] : phase[idx][ACC_W-1 -: 15];
        end
        DRAIN: begin
          dcnt <= dcnt + DCNT_W'(1);
          sum  <= sum_nxt;
          if (drain_done) begin
            mix_data  <= sum_nxt[SUM_W-1:IDX_W];
            mix_valid <= 1'b1;
          end
        end
        OUTPUT: begin
          if (mix_ready) mix_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Voice registers: config write wins; a disabling write clears phase over an advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      en <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= '0;
        fcw[v]   <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (cfg_we && cfg_voice == IDX_W'(v)) begin
          fcw[v] <= cfg_fcw;
          en[v]  <= cfg_en;
        end
        if (cfg_we && cfg_voice == IDX_W'(v) && !cfg_en)
          phase[v] <= '0;
        else if (state == ISSUE && idx == IDX_W'(v) && en[v])
          phase[v] <= adv_phase;
      end
    end
  end

endmodule

// File: tb/tb_synth_voice_scheduler.sv
// Testbench for synth_voice_scheduler: directed passes, square-wave generator
// model, expected-mix queue checked by an independent output monitor.
module tb_synth_voice_scheduler;

  localparam int NUM_VOICES = 4;
  localparam int ACC_W      = 24;
  localparam int GEN_LAT    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic        cfg_we;
  logic [1:0]  cfg_voice;
  logic [23:0] cfg_fcw;
  logic        cfg_en;
  logic [14:0] gen_phase;
  logic [11:0] gen_wave;
  logic [11:0] mix_data;
  logic        mix_valid;
  logic        mix_ready;
  logic        busy;
  logic        overrun;

  logic [11:0] gen_pipe [GEN_LAT] = '{default: 12'd0};
  logic [11:0] exp_q [$];
  logic [11:0] mon_exp;
  int          n_vec = 0;
  int          n_err = 0;

  synth_voice_scheduler #(
    .NUM_VOICES(NUM_VOICES), .ACC_W(ACC_W), .GEN_LAT(GEN_LAT)
  ) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_fcw(cfg_fcw), .cfg_en(cfg_en),
    .gen_phase(gen_phase), .gen_wave(gen_wave),
    .mix_data(mix_data), .mix_valid(mix_valid), .mix_ready(mix_ready),
    .busy(busy), .overrun(overrun)
  );

  // Clock.
  always #5 clk = ~clk;

  // Square-wave generator: 4095 in the low half of the phase circle, 0 in the high half.
  always @(posedge clk) begin
    gen_pipe[0] <= gen_phase[14] ? 12'd0 : 12'd4095;
    for (int i = 1; i < GEN_LAT; i++) gen_pipe[i] <= gen_pipe[i-1];
  end
  assign gen_wave = gen_pipe[GEN_LAT-1];

  // Output monitor: every transfer pops one expected mix value.
  always @(negedge clk) begin
    if (mix_valid && mix_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL mix_unexpected: got 0x%0h, expected no transfer", mix_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mix_data !== mon_exp) begin
          n_err++;
          $display("FAIL mix_data: got 0x%0h, expected 0x%0h", mix_data, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns 1ns after the edge that samples the tick (edge T).
  task automatic do_tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] v, input logic [23:0] f, input logic e);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_voice = v;
    cfg_fcw   = f;
    cfg_en    = e;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check(name, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    sample_tick = 1'b0;
    cfg_we      = 1'b0;
    cfg_voice   = '0;
    cfg_fcw     = '0;
    cfg_en      = 1'b0;
    mix_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Quiet after reset for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (i % 10 == 0) begin
        check("rst_mix_valid", mix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_gen_phase", gen_phase, 0);
      end
    end

    // Single voice, exact latency.
    cfg_write(2'd0, 24'h000100, 1'b1);
    exp_q.push_back(12'd1023);
    do_tick();
    @(posedge clk); #1;
    check("v0_gen_phase_t1", gen_phase, 0);
    check("v0_busy_t1", busy, 1);
    repeat (5) @(posedge clk);
    #1;
    check("v0_valid_t6", mix_valid, 0);
    @(posedge clk); #1;
    check("v0_valid_t7", mix_valid, 1);
    check("v0_data_t7", mix_data, 12'd1023);
    @(posedge clk); #1;
    check("v0_valid_t8", mix_valid, 0);
    check("v0_busy_t8", busy, 0);

    // All voices enabled, all phases in the low half.
    cfg_write(2'd1, 24'h000010, 1'b1);
    cfg_write(2'd2, 24'h000020, 1'b1);
    cfg_write(2'd3, 24'h000030, 1'b1);
    exp_q.push_back(12'd4095);
    do_tick();
    wait_idle("all_on_done");

    // Phase wrap: voice0 alone with fcw = half circle.
    cfg_write(2'd1, 24'h0, 1'b0);
    cfg_write(2'd2, 24'h0, 1'b0);
    cfg_write(2'd3, 24'h0, 1'b0);
    cfg_write(2'd0, 24'h0, 1'b0);
    cfg_write(2'd0, 24'h800000, 1'b1);
    exp_q.push_back(12'd0);
    do_tick();
    @(posedge clk); #1;
    check("wrap_gen_phase_1", gen_phase, 15'h4000);
    wait_idle("wrap_done_1");
    exp_q.push_back(12'd1023);
    do_tick();
    @(posedge clk); #1;
    check("wrap_gen_phase_2", gen_phase, 15'h0000);
    wait_idle("wrap_done_2");

    // Backpressure with an overlapping tick.
    cfg_write(2'd0, 24'h000100, 1'b1);
    mix_ready = 1'b0;
    exp_q.push_back(12'd1023);
    do_tick();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mix_valid) break;
    end
    check("stall_valid_up", mix_valid, 1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        @(negedge clk);
        sample_tick = 1'b1;
      end
      @(posedge clk); #1;
      sample_tick = 1'b0;
      check("stall_valid_hold", mix_valid, 1);
      check("stall_data_hold", mix_data, 12'd1023);
    end
    check("stall_overrun", overrun, 1);
    check("stall_busy", busy, 1);
    mix_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_valid", mix_valid, 0);
    check("stall_release_busy", busy, 0);
    repeat (15) @(posedge clk);
    #1;
    check("no_extra_pass", busy, 0);

    // Disable voice2 during its own slot.
    check("overrun_sticky", overrun, 1);
    cfg_write(2'd2, 24'h001000, 1'b1);
    exp_q.push_back(12'd2047);
    do_tick();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_voice = 2'd2;
    cfg_fcw   = 24'h001000;
    cfg_en    = 1'b0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("slot_old_en_gen_phase", gen_phase, 15'd8);
    wait_idle("slot_pass_a_done");
    exp_q.push_back(12'd1023);
    do_tick();
    repeat (3) @(posedge clk);
    #1;
    check("slot_cleared_gen_phase", gen_phase, 15'd0);
    wait_idle("slot_pass_b_done");

    // Reset in the middle of a pass.
    do_tick();
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_mix_valid", mix_valid, 0);
    check("midrst_mix_data", mix_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_gen_phase", gen_phase, 0);
    repeat (15) @(posedge clk);
    #1;
    check("midrst_quiet", mix_valid, 0);
    cfg_write(2'd0, 24'h000100, 1'b1);
    exp_q.push_back(12'd1023);
    do_tick();
    @(posedge clk); #1;
    check("midrst_phase_restart", gen_phase, 15'd0);
    wait_idle("midrst_recover_done");

    repeat (5) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
